fft_r2_sched: RTL

Sequencing controller for an in-place radix-2 decimation-in-time FFT built around one shared combinational `butterfly` unit. On `i_start` it walks every stage and every butterfly of an N-point transform. For each butterfly it issues x/y read addresses to a dual-port data memory and a twiddle ROM address. It then issues write-back addresses one cycle later, when the butterfly results are valid. Input data is already in bit-reversed order in memory; this block does no data path work.

---
 rtl/fft_r2_sched.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fft_r2_sched.sv
// fft_r2_sched
// Address/strobe sequencer for an in-place radix-2 DIT FFT that shares a
// single combinational butterfly. Each RUN cycle issues one butterfly's
// operand and twiddle addresses. The matching write-back addresses follow one
// cycle later, after the 1-cycle memory read latency.
//
// Ports
//   clk          clock
//   i_rst_n      asynchronous active-low reset
//   i_start      start request, honoured only in IDLE
//   o_busy       high in RUN and DRAIN
//   o_done       one-cycle completion pulse
//   o_stage      current stage index s
//   o_rd_en      read strobe for the x/y operands
//   o_rd_addr_x  x operand read address
//   o_rd_addr_y  y operand read address
//   o_tw_addr    twiddle ROM index k (W_N^k, k < N/2)
//   o_wr_en      write strobe for the butterfly results
//   o_wr_addr_x  x result write address
//   o_wr_addr_y  y result write address
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for i_start
// RUN   | issuing one butterfly per cycle for stage s
// DRAIN | one bubble so the stage's last write lands before next reads
// DONE  | o_done pulse, then back to IDLE

module fft_r2_sched #(
  parameter  int LOG2N = 4,
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1,
  localparam int KW    = LOG2N - 1
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [SW-1:0]    o_stage,
  output logic             o_rd_en,
  output logic [LOG2N-1:0] o_rd_addr_x,
  output logic [LOG2N-1:0] o_rd_addr_y,
  output logic [KW-1:0]    o_tw_addr,
  output logic             o_wr_en,
  output logic [LOG2N-1:0] o_wr_addr_x,
  output logic [LOG2N-1:0] o_wr_addr_y
);

  localparam int SW1 = SW + 1;
  localparam logic [SW-1:0] S_LAST = SW'(LOG2N - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [SW-1:0]     s_q, s_d;
  logic [KW-1:0]     k_q, k_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [LOG2N-1:0]  rd_x_q, rd_x_d;
  logic [LOG2N-1:0]  rd_y_q, rd_y_d;
  logic [KW-1:0]     tw_q, tw_d;
  logic              wr_en_q;
  logic [LOG2N-1:0]  wr_x_q, wr_y_q;

  logic [LOG2N-1:0]  k_ext, span, pos, grp, x_raw;
  logic [SW1-1:0]    tw_sh;

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    k_d     = k_q;
    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d = S_RUN;
          s_d     = '0;
          k_d     = '0;
        end
      end
      S_RUN: begin
        if (&k_q) state_d = S_DRAIN;
        else      k_d     = k_q + KW'(1);
      end
      S_DRAIN: begin
        if (s_q == S_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
          s_d     = s_q + SW'(1);
          k_d     = '0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        s_d     = '0;
        k_d     = '0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, so they are computed from the next-state values.
  always_comb begin
    busy_d  = (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d  = (state_d == S_DONE);
    rd_en_d = (state_d == S_RUN);

    k_ext = {1'b0, k_d};
    span  = LOG2N'(1) << s_d;
    pos   = k_ext & (span - LOG2N'(1));
    grp   = k_ext >> s_d;
    x_raw = ((grp << s_d) << 1) | pos;
    // Bits of k above pos shift out of the KW-bit result, so shifting k
    // directly gives pos << (LOG2N-1-s).
    tw_sh = SW1'(KW) - SW1'(s_d);

    rd_x_d = '0;
    rd_y_d = '0;
    tw_d   = '0;
    if (rd_en_d) begin
      rd_x_d = x_raw;
      rd_y_d = x_raw | span;
      tw_d   = k_d << tw_sh;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      s_q     <= '0;
      k_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      rd_x_q  <= '0;
      rd_y_q  <= '0;
      tw_q    <= '0;
      wr_en_q <= 1'b0;
      wr_x_q  <= '0;
      wr_y_q  <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      k_q     <= k_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      rd_x_q  <= rd_x_d;
      rd_y_q  <= rd_y_d;
      tw_q    <= tw_d;
      // In-place write-back: reuse last cycle's read addresses.
      wr_en_q <= rd_en_q;
      wr_x_q  <= rd_x_q;
      wr_y_q  <= rd_y_q;
    end
  end

  assign o_busy      = busy_q;
  assign o_done      = done_q;
  assign o_stage     = s_q;
  assign o_rd_en     = rd_en_q;
  assign o_rd_addr_x = rd_x_q;
  assign o_rd_addr_y = rd_y_q;
  assign o_tw_addr   = tw_q;
  assign o_wr_en     = wr_en_q;
  assign o_wr_addr_x = wr_x_q;
  assign o_wr_addr_y = wr_y_q;

endmodule
